// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans two 4-digit multiplexed 7-segment banks.
// Bank1 shows HH.MM, bank0 shows SS, a mode glyph and an info digit.
// Display data is sampled once per scan frame so a frame never tears.
module seg_scan_driver #(
   parameter int SCAN_DIV     = 25000,
   parameter int BLINK_FRAMES = 250
) (
   input  logic        clk_sys,
   input  logic        rstn,
   input  logic [19:0] time_data,
   input  logic [5:0]  state_info,
   output logic [6:0]  led0,
   output logic [6:0]  led1,
   output logic [3:0]  led_mux0,
   output logic [3:0]  led_mux1,
   output logic        dp0,
   output logic        dp1
);

   localparam int             CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0]  SCAN_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [9:0]     BLINK_LAST = 10'(BLINK_FRAMES - 1);

   localparam logic [2:0] M_IDLE   = 3'd0;
   localparam logic [2:0] M_SET    = 3'd1;
   localparam logic [2:0] M_ALARM  = 3'd2;
   localparam logic [2:0] M_TIMING = 3'd3;
   localparam logic [2:0] M_SELECT = 3'd4;

   localparam logic [6:0] G_BLANK = 7'h00;
   localparam logic [6:0] G_DASH  = 7'h40;

   // BCD digit to segments; anything above 9 shows a dash
   function automatic logic [6:0] digit_glyph(input logic [3:0] d);
      case (d)
         4'd0:    digit_glyph = 7'h3F;
         4'd1:    digit_glyph = 7'h06;
         4'd2:    digit_glyph = 7'h5B;
         4'd3:    digit_glyph = 7'h4F;
         4'd4:    digit_glyph = 7'h66;
         4'd5:    digit_glyph = 7'h6D;
         4'd6:    digit_glyph = 7'h7D;
         4'd7:    digit_glyph = 7'h07;
         4'd8:    digit_glyph = 7'h7F;
         4'd9:    digit_glyph = 7'h6F;
         default: digit_glyph = G_DASH;
      endcase
   endfunction

   logic [CW-1:0] scan_cnt;
   logic [1:0]    idx;
   logic [9:0]    blink_cnt;
   logic          blink_on;
   logic [19:0]   snap_t;
   logic [5:0]    snap_s;
   logic          tick;
   logic          frame_end;

   assign tick      = (scan_cnt == SCAN_LAST);
   assign frame_end = tick && (idx == 2'd3);

   // Slot timer, digit index, per-frame snapshot and blink phase
   always_ff @(posedge clk_sys) begin
      if (!rstn) begin
         scan_cnt  <= '0;
         idx       <= 2'd0;
         blink_cnt <= 10'd0;
         blink_on  <= 1'b1;
         snap_t    <= '0;
         snap_s    <= '0;
      end else begin
         scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
         if (tick) idx <= idx + 2'd1;
         if (frame_end) begin
            snap_t <= time_data;
            snap_s <= state_info;
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt <= 10'd0;
               blink_on  <= ~blink_on;
            end else begin
               blink_cnt <= blink_cnt + 10'd1;
            end
         end
      end
   end

   logic [2:0] mode;
   logic [2:0] info;
   logic [6:0] mode_g;
   logic [6:0] info_g;
   logic [6:0] nxt_led0;
   logic [6:0] nxt_led1;
   logic       nxt_dp0;
   logic       nxt_dp1;

   assign mode = snap_s[2:0];
   assign info = snap_s[5:3];

   // Decode the current slot of both banks from the snapshot
   always_comb begin
      mode_g   = G_DASH;
      info_g   = G_DASH;
      nxt_led0 = G_BLANK;
      nxt_led1 = G_BLANK;
      nxt_dp0  = 1'b0;
      nxt_dp1  = 1'b0;
      case (mode)
         M_IDLE:   mode_g = G_BLANK;
         M_SET:    mode_g = 7'h6D;
         M_ALARM:  mode_g = 7'h77;
         M_TIMING: mode_g = 7'h78;
         M_SELECT: mode_g = 7'h73;
         default:  mode_g = G_DASH;
      endcase
      case (mode)
         M_IDLE, M_SET:     info_g = G_BLANK;
         M_ALARM, M_TIMING: info_g = digit_glyph({2'b00, info[1:0]});
         M_SELECT:          info_g = blink_on ? digit_glyph({1'b0, info}) : G_BLANK;
         default:           info_g = G_DASH;
      endcase
      case (idx)
         2'd3: begin
            nxt_led1 = digit_glyph({2'b00, snap_t[19:18]});
            nxt_led0 = digit_glyph({1'b0, snap_t[6:4]});
         end
         2'd2: begin
            nxt_led1 = digit_glyph(snap_t[17:14]);
            nxt_led0 = digit_glyph(snap_t[3:0]);
            nxt_dp1  = 1'b1;
            // stopwatch running: the seconds point blinks
            nxt_dp0  = (mode == M_TIMING && info[2]) ? blink_on : 1'b1;
         end
         2'd1: begin
            nxt_led1 = digit_glyph({1'b0, snap_t[13:11]});
            nxt_led0 = mode_g;
         end
         default: begin
            nxt_led1 = digit_glyph(snap_t[10:7]);
            nxt_led0 = info_g;
            nxt_dp1  = 1'b1;
         end
      endcase
   end

   // Register all pin outputs one cycle behind idx
   always_ff @(posedge clk_sys) begin
      if (!rstn) begin
         led0     <= 7'd0;
         led1     <= 7'd0;
         led_mux0 <= 4'b0001;
         led_mux1 <= 4'b0001;
         dp0      <= 1'b0;
         dp1      <= 1'b0;
      end else begin
         led0     <= nxt_led0;
         led1     <= nxt_led1;
         led_mux0 <= 4'b0001 << idx;
         led_mux1 <= 4'b0001 << idx;
         dp0      <= nxt_dp0;
         dp1      <= nxt_dp1;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLINK_FRAMES=2.
// Edge E0 is the first rising edge with rstn high; frame f slot i is
// sampled on the falling edge after E(16f+4i+1).
module tb_seg_scan_driver;

   logic        clk_sys = 1'b0;
   logic        rstn;
   logic [19:0] time_data;
   logic [5:0]  state_info;
   logic [6:0]  led0, led1;
   logic [3:0]  led_mux0, led_mux1;
   logic        dp0, dp1;

   seg_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
      .clk_sys    (clk_sys),
      .rstn       (rstn),
      .time_data  (time_data),
      .state_info (state_info),
      .led0       (led0),
      .led1       (led1),
      .led_mux0   (led_mux0),
      .led_mux1   (led_mux1),
      .dp0        (dp0),
      .dp1        (dp1)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct packed {
      logic [3:0] mux;
      logic [6:0] l0;
      logic [6:0] l1;
      logic       d0;
      logic       d1;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   n      = -1;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance to just after edge t, then to the following falling edge
   task automatic tick_to(input int t);
      while (n < t) begin
         @(posedge clk_sys);
         n++;
      end
      @(negedge clk_sys);
   endtask

   // b1/b0 are {idx3,idx2,idx1,idx0} glyphs; dp masks indexed by idx
   task automatic push_frame(input logic [27:0] b1, input logic [27:0] b0,
                             input logic [3:0] dp1m, input logic [3:0] dp0m);
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         e.mux = 4'b0001 << i;
         e.l1  = b1[7*i +: 7];
         e.l0  = b0[7*i +: 7];
         e.d1  = dp1m[i];
         e.d0  = dp0m[i];
         sb.push_back(e);
      end
   endtask

   task automatic check_slots(input int f, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         exp_t e;
         tick_to(16*f + 4*i + 1);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty f%0d s%0d observed=0 expected=1", f, i);
         end else begin
            e = sb.pop_front();
            chk($sformatf("mux0 f%0d s%0d", f, i), {4'b0, led_mux0}, {4'b0, e.mux});
            chk($sformatf("mux1 f%0d s%0d", f, i), {4'b0, led_mux1}, {4'b0, e.mux});
            chk($sformatf("led1 f%0d s%0d", f, i), {1'b0, led1}, {1'b0, e.l1});
            chk($sformatf("led0 f%0d s%0d", f, i), {1'b0, led0}, {1'b0, e.l0});
            chk($sformatf("dp1 f%0d s%0d", f, i), {7'b0, dp1}, {7'b0, e.d1});
            chk($sformatf("dp0 f%0d s%0d", f, i), {7'b0, dp0}, {7'b0, e.d0});
         end
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " led0"}, {1'b0, led0}, 8'h00);
      chk({tag, " led1"}, {1'b0, led1}, 8'h00);
      chk({tag, " mux0"}, {4'b0, led_mux0}, 8'h01);
      chk({tag, " mux1"}, {4'b0, led_mux1}, 8'h01);
      chk({tag, " dp0"}, {7'b0, dp0}, 8'h00);
      chk({tag, " dp1"}, {7'b0, dp1}, 8'h00);
   endtask

   localparam logic [27:0] B1_T2 = {7'h06, 7'h7F, 7'h3F, 7'h7D};

   initial begin
      rstn       = 1'b0;
      time_data  = {2'd2, 4'd3, 3'd5, 4'd9, 3'd4, 4'd7};
      state_info = {3'd0, 3'd0};
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      chk_reset_vals("reset");

      // release and follow the digit select cycle by cycle
      rstn = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         tick_to(k);
         chk($sformatf("seq mux0 e%0d", k), {4'b0, led_mux0}, {4'b0, 4'b0001 << ((k / 4) % 4)});
         chk($sformatf("seq mux1 e%0d", k), {4'b0, led_mux1}, {4'b0, 4'b0001 << ((k / 4) % 4)});
      end

      // frame 1: 23:59 / 47 idle; inputs change mid-frame without tearing
      push_frame({7'h5B, 7'h4F, 7'h6D, 7'h6F}, {7'h66, 7'h07, 7'h00, 7'h00}, 4'b0101, 4'b0100);
      check_slots(1, 0, 1);
      time_data  = {2'd1, 4'd8, 3'd0, 4'd6, 3'd5, 4'hC};
      state_info = {3'd0, 3'd7};
      check_slots(1, 2, 3);

      // frame 2: 18:06, sec_l invalid, mode 7
      push_frame(B1_T2, {7'h6D, 7'h40, 7'h40, 7'h40}, 4'b0101, 4'b0100);
      check_slots(2, 0, 3);

      // frames 3..6: SELECT, info 6 blinks two frames off, two on
      state_info = {3'd6, 3'd4};
      push_frame(B1_T2, {7'h6D, 7'h40, 7'h73, 7'h00}, 4'b0101, 4'b0100);
      check_slots(3, 0, 3);
      push_frame(B1_T2, {7'h6D, 7'h40, 7'h73, 7'h7D}, 4'b0101, 4'b0100);
      check_slots(4, 0, 3);
      push_frame(B1_T2, {7'h6D, 7'h40, 7'h73, 7'h7D}, 4'b0101, 4'b0100);
      check_slots(5, 0, 3);
      push_frame(B1_T2, {7'h6D, 7'h40, 7'h73, 7'h00}, 4'b0101, 4'b0100);
      check_slots(6, 0, 3);

      // frames 7..10: TIMING running, seconds point follows blink phase
      state_info = {3'b100, 3'd3};
      push_frame(B1_T2, {7'h6D, 7'h40, 7'h78, 7'h3F}, 4'b0101, 4'b0000);
      check_slots(7, 0, 3);
      push_frame(B1_T2, {7'h6D, 7'h40, 7'h78, 7'h3F}, 4'b0101, 4'b0100);
      check_slots(8, 0, 3);
      push_frame(B1_T2, {7'h6D, 7'h40, 7'h78, 7'h3F}, 4'b0101, 4'b0100);
      check_slots(9, 0, 3);
      push_frame(B1_T2, {7'h6D, 7'h40, 7'h78, 7'h3F}, 4'b0101, 4'b0000);
      check_slots(10, 0, 3);

      // reset in the middle of frame 11, slot 1
      tick_to(16*11 + 5);
      chk("pre-reset mux0", {4'b0, led_mux0}, 8'h02);
      rstn = 1'b0;
      @(posedge clk_sys);
      @(negedge clk_sys);
      chk_reset_vals("midreset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
